// File: rtl/ship_placement_ctrl.sv
//==============================================================================
// Module   : ship_placement_ctrl
// Brief    : Cursor-driven ship placement front end; validates each placement
//            against an occupancy bitmap and emits a one-hot ship write enable.
//            Optional macro CURSOR_WRAP_EN: cursor wraps instead of saturating.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module ship_placement_ctrl #(
    parameter int NUM_SHIPS = 5,
    parameter int BOARD_DIM = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_place,
    output logic [4:0]                     cursor_idx,
    output logic [4:0]                     casilla,
    output logic [NUM_SHIPS-1:0]           wr_en,
    output logic [BOARD_DIM*BOARD_DIM-1:0] occupied,
    output logic [2:0]                     ship_count,
    output logic                           reject,
    output logic                           busy,
    output logic                           done
);

    localparam int c_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int c_RW    = (BOARD_DIM > 1) ? $clog2(BOARD_DIM) : 1;
    localparam logic [c_RW-1:0] c_MAX = c_RW'(BOARD_DIM - 1);
    localparam logic [c_RW-1:0] c_ONE = c_RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_RW-1:0]       r_row;
    logic [c_RW-1:0]       r_col;
    logic [4:0]            r_cursor_idx;
    logic [4:0]            r_casilla;
    logic [NUM_SHIPS-1:0]  r_wr_en;
    logic [c_CELLS-1:0]    r_occupied;
    logic [2:0]            r_ship_count;
    logic                  r_reject;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [c_RW-1:0]       w_row_nxt;
    logic [c_RW-1:0]       w_col_nxt;
    logic [4:0]            w_cursor_nxt;
    logic [4:0]            w_casilla_nxt;
    logic [NUM_SHIPS-1:0]  w_wr_en_nxt;
    logic [c_CELLS-1:0]    w_occ_nxt;
    logic [2:0]            w_cnt_nxt;
    logic                  w_reject_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    logic [c_RW-1:0]       w_row_dec;
    logic [c_RW-1:0]       w_row_inc;
    logic [c_RW-1:0]       w_col_dec;
    logic [c_RW-1:0]       w_col_inc;
    logic                  w_cur_occ;
    logic [c_CELLS-1:0]    w_cur_mask;
    logic [NUM_SHIPS-1:0]  w_wr_onehot;

    // Edge behaviour of a single cursor step
    always_comb begin
`ifdef CURSOR_WRAP_EN
        w_row_dec = (r_row == '0)    ? c_MAX : r_row - c_ONE;
        w_row_inc = (r_row == c_MAX) ? '0    : r_row + c_ONE;
        w_col_dec = (r_col == '0)    ? c_MAX : r_col - c_ONE;
        w_col_inc = (r_col == c_MAX) ? '0    : r_col + c_ONE;
`else
        w_row_dec = (r_row == '0)    ? '0    : r_row - c_ONE;
        w_row_inc = (r_row == c_MAX) ? c_MAX : r_row + c_ONE;
        w_col_dec = (r_col == '0)    ? '0    : r_col - c_ONE;
        w_col_inc = (r_col == c_MAX) ? c_MAX : r_col + c_ONE;
`endif
    end

    always_comb begin
        w_cur_occ  = 1'b0;
        w_cur_mask = '0;
        for (int i = 0; i < c_CELLS; i++) begin
            if (r_cursor_idx == 5'(i)) begin
                w_cur_occ     = r_occupied[i];
                w_cur_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_wr_onehot = '0;
        for (int k = 0; k < NUM_SHIPS; k++) begin
            if (r_ship_count == 3'(k)) begin
                w_wr_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_casilla_nxt = r_casilla;
        w_wr_en_nxt   = '0;
        w_occ_nxt     = r_occupied;
        w_cnt_nxt     = r_ship_count;
        w_reject_nxt  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_MOVE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_occ_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_MOVE: begin
                // One action per cycle; place wins over every move
                if (btn_place) begin
                    if (w_cur_occ) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_casilla_nxt = r_cursor_idx;
                        w_wr_en_nxt   = w_wr_onehot;
                        w_occ_nxt     = r_occupied | w_cur_mask;
                        w_cnt_nxt     = r_ship_count + 3'd1;
                        w_state_nxt   = ST_COMMIT;
                    end
                end else if (btn_up) begin
                    w_row_nxt = w_row_dec;
                end else if (btn_down) begin
                    w_row_nxt = w_row_inc;
                end else if (btn_left) begin
                    w_col_nxt = w_col_dec;
                end else if (btn_right) begin
                    w_col_nxt = w_col_inc;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = (r_ship_count == 3'(NUM_SHIPS)) ? ST_DONE : ST_MOVE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_cursor_nxt = 5'(32'(w_row_nxt) * BOARD_DIM + 32'(w_col_nxt));
        w_busy_nxt   = (w_state_nxt == ST_MOVE) || (w_state_nxt == ST_COMMIT);
        w_done_nxt   = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_cursor_idx <= '0;
            r_casilla    <= '0;
            r_wr_en      <= '0;
            r_occupied   <= '0;
            r_ship_count <= '0;
            r_reject     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_cursor_idx <= w_cursor_nxt;
            r_casilla    <= w_casilla_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_occupied   <= w_occ_nxt;
            r_ship_count <= w_cnt_nxt;
            r_reject     <= w_reject_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign cursor_idx = r_cursor_idx;
    assign casilla    = r_casilla;
    assign wr_en      = r_wr_en;
    assign occupied   = r_occupied;
    assign ship_count = r_ship_count;
    assign reject     = r_reject;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ship_placement_ctrl.sv
//==============================================================================
// Module   : tb_ship_placement_ctrl
// Brief    : Self-checking bench for ship_placement_ctrl against a board-level
//            reference model (honours CURSOR_WRAP_EN when defined).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ship_placement_ctrl;

    localparam int c_N = 5;
    localparam int c_D = 5;

    localparam logic [6:0] c_B_NONE  = 7'b0000000;
    localparam logic [6:0] c_B_PLACE = 7'b0000001;
    localparam logic [6:0] c_B_RIGHT = 7'b0000010;
    localparam logic [6:0] c_B_LEFT  = 7'b0000100;
    localparam logic [6:0] c_B_DOWN  = 7'b0001000;
    localparam logic [6:0] c_B_UP    = 7'b0010000;
    localparam logic [6:0] c_B_START = 7'b0100000;
    localparam logic [6:0] c_B_RST   = 7'b1000000;

    logic                 clk = 1'b0;
    logic                 rst, start, btn_up, btn_down, btn_left, btn_right, btn_place;
    logic [4:0]           cursor_idx, casilla;
    logic [c_N-1:0]       wr_en;
    logic [c_D*c_D-1:0]   occupied;
    logic [2:0]           ship_count;
    logic                 reject, busy, done;

    ship_placement_ctrl #(.NUM_SHIPS(c_N), .BOARD_DIM(c_D)) dut (
        .clk(clk), .rst(rst), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_place(btn_place),
        .cursor_idx(cursor_idx), .casilla(casilla), .wr_en(wr_en),
        .occupied(occupied), .ship_count(ship_count),
        .reject(reject), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 idle, 1 choosing a cell, 2 commit cycle, 3 finished
    int                 m_phase = 0;
    int                 m_row = 0, m_col = 0, m_cell = 0, m_placed = 0;
    logic [c_D*c_D-1:0] m_board = '0;
    logic [c_N-1:0]     m_wr = '0;
    logic               m_rej = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model(input logic [6:0] b);
        int here;
        here  = m_row * c_D + m_col;
        m_wr  = '0;
        m_rej = 1'b0;
        if (b[6]) begin
            m_phase = 0; m_row = 0; m_col = 0; m_cell = 0; m_placed = 0; m_board = '0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (b[5]) begin
                m_phase = 1; m_row = 0; m_col = 0; m_placed = 0; m_board = '0;
            end
        end else if (m_phase == 2) begin
            m_phase = (m_placed == c_N) ? 3 : 1;
        end else if (b[0]) begin
            if (m_board[here]) m_rej = 1'b1;
            else begin
                m_cell = here;
                m_wr[m_placed] = 1'b1;
                m_board[here] = 1'b1;
                m_placed++;
                m_phase = 2;
            end
        end else begin
`ifdef CURSOR_WRAP_EN
            if (b[4])      m_row = (m_row + c_D - 1) % c_D;
            else if (b[3]) m_row = (m_row + 1) % c_D;
            else if (b[2]) m_col = (m_col + c_D - 1) % c_D;
            else if (b[1]) m_col = (m_col + 1) % c_D;
`else
            if (b[4])      m_row = (m_row > 0) ? m_row - 1 : 0;
            else if (b[3]) m_row = (m_row < c_D - 1) ? m_row + 1 : c_D - 1;
            else if (b[2]) m_col = (m_col > 0) ? m_col - 1 : 0;
            else if (b[1]) m_col = (m_col < c_D - 1) ? m_col + 1 : c_D - 1;
`endif
        end
    endtask

    task automatic compare_all();
        chk("cursor_idx", 32'(cursor_idx), 32'(m_row * c_D + m_col));
        chk("casilla",    32'(casilla),    32'(m_cell));
        chk("wr_en",      32'(wr_en),      32'(m_wr));
        chk("occupied",   32'(occupied),   32'(m_board));
        chk("ship_count", 32'(ship_count), 32'(m_placed));
        chk("reject",     32'(reject),     32'(m_rej));
        chk("busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
        chk("done",       32'(done),       32'(m_phase == 3));
    endtask

    task automatic step(input logic [6:0] b);
        {rst, start, btn_up, btn_down, btn_left, btn_right, btn_place} = b;
        @(posedge clk);
        model(b);
        #1;
        compare_all();
    endtask

    initial begin
        logic [6:0] b;
        int r;
        {rst, start, btn_up, btn_down, btn_left, btn_right, btn_place} = '0;

        // Reset, then buttons in idle are ignored
        step(c_B_RST);
        step(c_B_RST);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        step(c_B_DOWN | c_B_RIGHT);
        step(c_B_PLACE);
        chk("idle_cursor", 32'(cursor_idx), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Move to cell 7 and place
        step(c_B_START);
        step(c_B_RIGHT);
        step(c_B_RIGHT);
        step(c_B_DOWN);
        chk("cursor_7", 32'(cursor_idx), 32'd7);
        step(c_B_PLACE);
        chk("commit_casilla", 32'(casilla), 32'd7);
        chk("commit_wr_en", 32'(wr_en), 32'b00001);
        chk("commit_occ7", 32'(occupied[7]), 32'd1);
        step(c_B_NONE);
        chk("wr_en_cleared", 32'(wr_en), 32'd0);

        // Re-placing on an occupied cell is refused
        step(c_B_PLACE);
        chk("reject_pulse", 32'(reject), 32'd1);
        chk("reject_count", 32'(ship_count), 32'd1);
        step(c_B_NONE);
        chk("reject_gone", 32'(reject), 32'd0);

        // Full session at cells 0..4
        step(c_B_RST);
        step(c_B_START);
        for (int s = 0; s < c_N; s++) begin
            if (s > 0) step(c_B_RIGHT);
            step(c_B_PLACE);
            chk("seq_wr_en", 32'(wr_en), 32'(1) << s);
            step(c_B_NONE);
        end
        chk("session_done", 32'(done), 32'd1);
        step(c_B_PLACE | c_B_LEFT);
        chk("done_ignores", 32'(ship_count), 32'd5);

        // Edge behaviour at (0,0)
        step(c_B_START);
        step(c_B_UP);
`ifdef CURSOR_WRAP_EN
        chk("edge_up", 32'(cursor_idx), 32'd20);
`else
        chk("edge_up", 32'(cursor_idx), 32'd0);
`endif
        step(c_B_LEFT);
`ifdef CURSOR_WRAP_EN
        chk("edge_left", 32'(cursor_idx), 32'd24);
`else
        chk("edge_left", 32'(cursor_idx), 32'd0);
`endif

        // Place wins over right; reset during COMMIT kills the pulse
        step(c_B_RST);
        step(c_B_START);
        repeat (3) step(c_B_RIGHT);
        step(c_B_PLACE | c_B_RIGHT);
        chk("prio_casilla", 32'(casilla), 32'd3);
        chk("prio_cursor", 32'(cursor_idx), 32'd3);
        step(c_B_RST | c_B_PLACE);
        chk("rst_commit_wr", 32'(wr_en), 32'd0);
        chk("rst_commit_occ", 32'(occupied), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 999));
            b = '0;
            b[6] = (r < 4);
            b[5] = (r >= 4 && r < 40);
            b[4] = ($urandom_range(0, 5) == 0);
            b[3] = ($urandom_range(0, 4) == 0);
            b[2] = ($urandom_range(0, 5) == 0);
            b[1] = ($urandom_range(0, 4) == 0);
            b[0] = ($urandom_range(0, 5) == 0);
            step(b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ship_placement_ctrl.md
Name: ship_placement_ctrl

Overview:
Upstream stage of the per-ship position registers. It drives a cursor on the BOARD_DIM x BOARD_DIM board from debounced button pulses, validates each placement against a board occupancy bitmap, and emits the cell index with a one-cycle one-hot write enable to the target ship register. It is used during the setup phase of each player's turn and signals done once every ship is placed.

Parameters:
NUM_SHIPS, 5, number of ship registers fed; one write-enable bit per ship.
BOARD_DIM, 5, board side length; cell index = row*BOARD_DIM + col; BOARD_DIM*BOARD_DIM must be <= 32.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle pulse; begins a placement session
btn_up  in  1  single-cycle pulse, cursor row-1
btn_down  in  1  single-cycle pulse, cursor row+1
btn_left  in  1  single-cycle pulse, cursor col-1
btn_right  in  1  single-cycle pulse, cursor col+1
btn_place  in  1  single-cycle pulse, place the next ship at the cursor
cursor_idx  out  5  current cursor cell index (registered)
casilla  out  5  cell index presented to the ship registers; holds the last committed value
wr_en  out  NUM_SHIPS  one-hot write enable, bit k targets ship k; high for exactly 1 cycle per commit
occupied  out  BOARD_DIM*BOARD_DIM  bitmap of placed cells
ship_count  out  3  number of ships placed so far
reject  out  1  1-cycle pulse when a placement is refused
busy  out  1  high in states MOVE and COMMIT
done  out  1  high in state DONE

Behaviour:
- Reset (rst=1 at a clk edge, with priority over every other input):
  - state=IDLE; cursor row=col=0; cursor_idx=0; casilla=0; wr_en=0; occupied=0; ship_count=0; reject=0; busy=0; done=0.
- All outputs are registered.
- States and transitions:
  - IDLE: waits for start, then goes to MOVE with cursor (0,0), occupied=0, ship_count=0.
  - MOVE: processes button pulses.
  - COMMIT: lasts 1 cycle, then goes to DONE if ship_count==NUM_SHIPS, otherwise back to MOVE.
  - DONE: holds every output; start returns to MOVE with a cleared session, identical to leaving IDLE.
- MOVE, at most one action per cycle. Priority: btn_place > btn_up > btn_down > btn_left > btn_right. Lower-priority pulses in the same cycle are dropped.
- Cursor moves in MOVE:
  - The selected direction updates row or col; cursor_idx updates on the same edge.
  - Moves saturate at 0 and BOARD_DIM-1 (default build).
- btn_place in MOVE, cycle N:
  - If occupied[cursor_idx]=1: reject=1 during cycle N+1, state stays MOVE, nothing else changes.
  - Otherwise, during cycle N+1: casilla=cursor_idx, wr_en[ship_count]=1, occupied[cursor_idx] set, ship_count incremented, state=COMMIT.
  - wr_en returns to 0 at cycle N+2.
  - The ship register therefore captures casilla on the edge ending cycle N+1.
- Button pulses in IDLE, COMMIT and DONE are ignored. Pulses arriving during COMMIT are lost, not queued.
- start while in MOVE or COMMIT is ignored. Only rst aborts a session.
- rst mid-session clears occupied and ship_count. Any wr_en pulse in flight is forced to 0 on the reset edge.
- wr_en is never multi-hot. It is 0 whenever reject=1.

Optional Feature:
CURSOR_WRAP_EN
- Defined: cursor moves wrap modulo BOARD_DIM (row 0 + up -> row BOARD_DIM-1; col BOARD_DIM-1 + right -> col 0).
- Undefined: moves saturate at the board edges as above.
- No other behaviour differs.

Test Plan:
1. rst=1 for 2 cycles, then idle -> every output 0; state IDLE; button pulses ignored (cursor_idx stays 0).
2. start, btn_right x2, btn_down x1, btn_place -> cursor_idx=7; one cycle after the place pulse: casilla=7, wr_en=5'b00001, occupied[7]=1, ship_count=1; wr_en=0 on the following cycle.
3. After scenario 2, btn_place again at cell 7 -> reject=1 for 1 cycle, wr_en stays 0, ship_count stays 1.
4. Place 5 ships at cells 0, 1, 2, 3, 4 -> wr_en pulses 00001, 00010, 00100, 01000, 10000 in order; done=1 after the 5th COMMIT; later btn_place is ignored.
5. At cursor (0,0) press btn_up and btn_left -> default build: cursor_idx stays 0; CURSOR_WRAP_EN build: cursor_idx=20, then 24.
6. btn_place and btn_right in the same cycle at cell 3 -> commit at cell 3, cursor unchanged. Separately, rst asserted during the COMMIT cycle -> wr_en=0 on the next cycle and all outputs at reset values.
